// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack handshake,
// upstream freeze while an access is outstanding, and the MEM/WB result register.
module mem_stage #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int BASE_ADDR      = 1024,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      mem_R_en,
  input  logic                      mem_W_en,
  input  logic                      WB_en_in,
  input  logic [REG_FILE_DEPTH-1:0] dest_in,
  input  logic [WORD_WIDTH-1:0]     alu_result,
  input  logic [WORD_WIDTH-1:0]     val_Rm,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      freeze,
  output logic                      WB_en,
  output logic [REG_FILE_DEPTH-1:0] WB_dest,
  output logic [WORD_WIDTH-1:0]     WB_value,
  output logic                      mem_err
);

  localparam int                    CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WORD_WIDTH-1:0] BASE     = WORD_WIDTH'(BASE_ADDR);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic mem_op;
  logic is_store;
  logic fault;
  logic cnt_last;

  // Out of range: below the base, or a word index that does not fit the memory.
  function automatic logic addr_fault(input logic [WORD_WIDTH-1:0] a);
    logic [WORD_WIDTH-1:0] word_off;
    word_off = (a - BASE) >> 2;
    return (a < BASE) || ((word_off >> ADDR_WIDTH) != '0);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [WORD_WIDTH-1:0] a);
    logic [WORD_WIDTH-1:0] word_off;
    word_off = (a - BASE) >> 2;
    return word_off[ADDR_WIDTH-1:0];
  endfunction

  assign mem_op   = valid_in & (mem_R_en | mem_W_en);
  assign is_store = mem_W_en & ~mem_R_en;
  assign fault    = addr_fault(alu_result);
  assign cnt_last = (cnt == CNT_LAST);

  // Freeze drops in the ack cycle and in the abort cycle so upstream can advance.
  always_comb begin
    freeze = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    freeze = mem_op & ~fault;
        WAIT:    freeze = ~mem_ack & ~cnt_last;
        default: freeze = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      WB_en     <= 1'b0;
      WB_dest   <= '0;
      WB_value  <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && fault) begin
            WB_en   <= 1'b0;
            mem_err <= 1'b1;
          end else if (mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= word_addr(alu_result);
            mem_wdata <= val_Rm;
            cnt       <= '0;
            state     <= WAIT;
            WB_en     <= 1'b0;
          end else begin
            WB_en    <= WB_en_in & valid_in;
            WB_dest  <= dest_in;
            WB_value <= alu_result;
          end
        end
        WAIT: begin
          // Ack takes priority over the timeout in the same cycle.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            WB_en    <= WB_en_in & ~mem_we;
            WB_dest  <= dest_in;
            WB_value <= mem_rdata;
          end else if (cnt_last) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            WB_en   <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            WB_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of addressing, stalls and write-back.
module tb_mem_stage;

  localparam int WW   = 32;
  localparam int RD   = 4;
  localparam int AW   = 16;
  localparam int BASE = 1024;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, mem_R_en, mem_W_en, WB_en_in;
  logic [RD-1:0] dest_in;
  logic [WW-1:0] alu_result, val_Rm, mem_rdata;
  logic          mem_ack;
  logic          mem_req, mem_we, freeze, WB_en, mem_err;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata, WB_value;
  logic [RD-1:0] WB_dest;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_err = 1'b0;

  mem_stage #(
    .WORD_WIDTH(WW), .REG_FILE_DEPTH(RD), .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_R_en(mem_R_en),
    .mem_W_en(mem_W_en), .WB_en_in(WB_en_in), .dest_in(dest_in),
    .alu_result(alu_result), .val_Rm(val_Rm), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze),
    .WB_en(WB_en), .WB_dest(WB_dest), .WB_value(WB_value), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; mem_R_en = 0; mem_W_en = 0; WB_en_in = 0;
    dest_in = '0; alu_result = '0; val_Rm = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    valid_in = 1; mem_R_en = 1; alu_result = 32'h408;
    step();
    step();
    vectors++; if (freeze !== 1'b0) begin miscompares++; $display("FAIL rst_freeze: got %b expected 0", freeze); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    vectors++; if (WB_en !== 1'b0) begin miscompares++; $display("FAIL rst_WB_en: got %b expected 0", WB_en); end
    vectors++; if (WB_dest !== '0) begin miscompares++; $display("FAIL rst_WB_dest: got %h expected 0", WB_dest); end
    vectors++; if (WB_value !== '0) begin miscompares++; $display("FAIL rst_WB_value: got %h expected 0", WB_value); end
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL rst_mem_err: got %b expected 0", mem_err); end
    idle_inputs();
    rst = 1'b0;
    exp_err = 1'b0;
    step();
  endtask

  // Non-memory op (or invalid slot): one-cycle pass-through to MEM/WB.
  task automatic do_alu(input string tag, input logic [WW-1:0] val, input logic [RD-1:0] dest,
                        input bit wben, input bit vld, input bit rd, input bit wr, input bit ack);
    valid_in = vld; mem_R_en = vld ? 1'b0 : rd; mem_W_en = vld ? 1'b0 : wr;
    WB_en_in = wben; dest_in = dest; alu_result = val; val_Rm = $urandom;
    mem_ack = ack; mem_rdata = ~val;
    #1;
    vectors++; if (freeze !== 1'b0) begin miscompares++; $display("FAIL %s_freeze: got %b expected 0", tag, freeze); end
    step();
    mem_ack = 0;
    vectors++; if (WB_en !== (vld & wben)) begin miscompares++; $display("FAIL %s_WB_en: got %b expected %b", tag, WB_en, vld & wben); end
    vectors++; if (WB_dest !== dest) begin miscompares++; $display("FAIL %s_WB_dest: got %h expected %h", tag, WB_dest, dest); end
    vectors++; if (WB_value !== val) begin miscompares++; $display("FAIL %s_WB_value: got %h expected %h", tag, WB_value, val); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL %s_mem_req: got %b expected 0", tag, mem_req); end
    vectors++; if (mem_err !== exp_err) begin miscompares++; $display("FAIL %s_mem_err: got %b expected %b", tag, mem_err, exp_err); end
    idle_inputs();
  endtask

  // One memory instruction; ack_at = WAIT cycle in which ack arrives (0 = never).
  task automatic do_mem(input string tag, input logic [WW-1:0] addr, input logic [WW-1:0] wdata,
                        input bit rd, input bit wr, input logic [RD-1:0] dest, input bit wben,
                        input int ack_at, input logic [WW-1:0] rdata);
    longint        off;
    bit            fault;
    logic [AW-1:0] waddr;
    bit            exp_we;
    off    = longint'(addr) - BASE;
    fault  = (off < 0) || ((off / 4) >= (longint'(1) << AW));
    waddr  = AW'(off / 4);
    exp_we = wr & ~rd;
    valid_in = 1; mem_R_en = rd; mem_W_en = wr; WB_en_in = wben;
    dest_in = dest; alu_result = addr; val_Rm = wdata; mem_ack = 0;
    #1;
    vectors++; if (freeze !== !fault) begin miscompares++; $display("FAIL %s_freeze0: got %b expected %b", tag, freeze, !fault); end
    step();
    if (fault) begin
      exp_err = 1'b1;
      vectors++; if ({mem_req, WB_en, mem_err} !== 3'b001) begin miscompares++; $display("FAIL %s_fault: got req/wb/err %b%b%b expected 001", tag, mem_req, WB_en, mem_err); end
    end else begin
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL %s_mem_req: got %b expected 1", tag, mem_req); end
      vectors++; if (mem_we !== exp_we) begin miscompares++; $display("FAIL %s_mem_we: got %b expected %b", tag, mem_we, exp_we); end
      vectors++; if (mem_addr !== waddr) begin miscompares++; $display("FAIL %s_mem_addr: got %h expected %h", tag, mem_addr, waddr); end
      vectors++; if (mem_wdata !== wdata) begin miscompares++; $display("FAIL %s_mem_wdata: got %h expected %h", tag, mem_wdata, wdata); end
      vectors++; if (WB_en !== 1'b0) begin miscompares++; $display("FAIL %s_bubble: got %b expected 0", tag, WB_en); end
      for (int k = 1; k <= TMO; k++) begin
        mem_ack   = (k == ack_at);
        mem_rdata = (k == ack_at) ? rdata : WW'($urandom);
        #1;
        vectors++; if (freeze !== (k != ack_at && k != TMO)) begin miscompares++; $display("FAIL %s_freeze_w%0d: got %b expected %b", tag, k, freeze, (k != ack_at && k != TMO)); end
        step();
        mem_ack = 0;
        if (k == ack_at) begin
          vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL %s_req_done: got %b expected 0", tag, mem_req); end
          vectors++; if (WB_en !== (rd & wben)) begin miscompares++; $display("FAIL %s_WB_en: got %b expected %b", tag, WB_en, rd & wben); end
          if (rd) begin
            vectors++; if (WB_dest !== dest) begin miscompares++; $display("FAIL %s_WB_dest: got %h expected %h", tag, WB_dest, dest); end
            vectors++; if (WB_value !== rdata) begin miscompares++; $display("FAIL %s_WB_value: got %h expected %h", tag, WB_value, rdata); end
          end
          vectors++; if (mem_err !== exp_err) begin miscompares++; $display("FAIL %s_err: got %b expected %b", tag, mem_err, exp_err); end
          break;
        end else if (k == TMO) begin
          exp_err = 1'b1;
          vectors++; if ({mem_req, WB_en, mem_err} !== 3'b001) begin miscompares++; $display("FAIL %s_timeout: got req/wb/err %b%b%b expected 001", tag, mem_req, WB_en, mem_err); end
        end else begin
          vectors++; if ({mem_req, WB_en} !== 2'b10) begin miscompares++; $display("FAIL %s_wait%0d: got req/wb %b%b expected 10", tag, k, mem_req, WB_en); end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_alu_op();
    do_alu("alu55", 32'h55, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_alu("alu_nowb", 32'hCAFE0001, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_alu("alu_invalid", 32'h408, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_alu("alu_ack_idle", 32'h1357, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_load();
    do_mem("load408", 32'h408, 32'h0, 1'b1, 1'b0, 4'd5, 1'b1, 3, 32'hDEADBEEF);
    do_mem("load_both", 32'h40C, 32'h77, 1'b1, 1'b1, 4'd6, 1'b1, 2, 32'h0BADF00D);
  endtask

  task automatic test_store();
    do_mem("store400", 32'h400, 32'h1234, 1'b0, 1'b1, 4'd4, 1'b1, 1, 32'hFFFF0000);
  endtask

  task automatic test_timeout();
    do_mem("timeout", 32'h500, 32'h0, 1'b1, 1'b0, 4'd8, 1'b1, 0, 32'h0);
    do_alu("after_to", 32'hA5A5A5A5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_mem("ack_at_tmo", 32'h600, 32'h0, 1'b1, 1'b0, 4'd10, 1'b1, TMO, 32'h600DCAFE);
  endtask

  task automatic test_fault();
    do_mem("fault3fc", 32'h3FC, 32'h0, 1'b1, 1'b0, 4'd5, 1'b1, 1, 32'h0);
    do_mem("last_word", 32'd263167, 32'h9, 1'b0, 1'b1, 4'd1, 1'b0, 2, 32'h0);
    do_mem("fault_hi", 32'd263168, 32'h9, 1'b0, 1'b1, 4'd1, 1'b0, 1, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_mem("b2b_st", 32'h800, 32'hABCD, 1'b0, 1'b1, 4'd2, 1'b1, 2, 32'h0);
    do_mem("b2b_ld", 32'h800, 32'h0, 1'b1, 1'b0, 4'd11, 1'b1, 1, 32'h12345678);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int            kind;
      int            ack;
      logic [WW-1:0] a;
      logic [RD-1:0] d;
      kind = $urandom_range(0, 9);
      d    = RD'($urandom);
      ack  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      if (kind <= 3) begin
        do_alu("rnd_alu", WW'($urandom), d, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'($urandom));
      end else if (kind <= 8) begin
        a = WW'(BASE + 4 * $urandom_range(0, 65535) + $urandom_range(0, 3));
        if (kind <= 6) do_mem("rnd_ld", a, WW'($urandom), 1'b1, 1'($urandom), d, 1'($urandom), ack, WW'($urandom));
        else           do_mem("rnd_st", a, WW'($urandom), 1'b0, 1'b1, d, 1'($urandom), ack, WW'($urandom));
      end else begin
        a = $urandom_range(0, 1) ? WW'($urandom_range(0, BASE - 1)) : WW'(263168 + $urandom_range(0, 100000));
        do_mem("rnd_fault", a, WW'($urandom), 1'b1, 1'b0, d, 1'b1, 1, WW'($urandom));
      end
    end
  endtask

  task automatic test_reset_mid();
    valid_in = 1; mem_R_en = 1; mem_W_en = 0; WB_en_in = 1; dest_in = 4'd12;
    alu_result = 32'h410; val_Rm = 32'h0; mem_ack = 0;
    step();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_req: got %b expected 1", mem_req); end
    step();
    rst = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req_drop: got %b expected 0", mem_req); end
    vectors++; if (freeze !== 1'b0) begin miscompares++; $display("FAIL rmid_freeze: got %b expected 0", freeze); end
    vectors++; if ({mem_we, mem_addr, WB_en, WB_dest, WB_value, mem_err} !== '0) begin miscompares++; $display("FAIL rmid_outputs: got nonzero %b/%h/%b/%h/%h/%b expected all 0", mem_we, mem_addr, WB_en, WB_dest, WB_value, mem_err); end
    idle_inputs();
    exp_err = 1'b0;
    step();
    rst = 1'b0;
    mem_ack = 1; mem_rdata = 32'hFEEDFACE;
    step();
    mem_ack = 0;
    vectors++; if ({mem_req, WB_en} !== 2'b00) begin miscompares++; $display("FAIL rmid_late_ack: got req/wb %b%b expected 00", mem_req, WB_en); end
    vectors++; if (WB_value === 32'hFEEDFACE) begin miscompares++; $display("FAIL rmid_late_value: got %h expected not FEEDFACE", WB_value); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_timeout();
    test_fault();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX/MEM pipeline register and the register file write-back port. It performs word loads and stores through a req/ack memory handshake, freezes upstream stages while an access is outstanding, and registers the MEM/WB result (`WB_en`, `WB_dest`, `WB_value`) that drives the register file's write port.

## Interface
- `WORD_WIDTH`, 32: data/address word width.
- `REG_FILE_DEPTH`, 4: register index width.
- `ADDR_WIDTH`, 16: memory word-address width.
- `BASE_ADDR`, 1024: byte address mapped to memory word 0.
- `TIMEOUT`, 16: maximum `WAIT` cycles before an access is aborted (≥2).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `valid_in` in 1: upstream instruction valid.
- `mem_R_en` in 1: instruction is a load.
- `mem_W_en` in 1: instruction is a store.
- `WB_en_in` in 1: instruction writes a register.
- `dest_in` in `REG_FILE_DEPTH`: destination register.
- `alu_result` in `WORD_WIDTH`: byte address for loads/stores; result otherwise.
- `val_Rm` in `WORD_WIDTH`: store data.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write, registered.
- `mem_addr` out `ADDR_WIDTH`: word address, registered.
- `mem_wdata` out `WORD_WIDTH`: write data, registered.
- `mem_rdata` in `WORD_WIDTH`: read data, valid with `mem_ack`.
- `mem_ack` in 1: access complete, one-cycle pulse.
- `freeze` out 1: combinational; upstream holds its inputs while high.
- `WB_en` out 1: registered write enable to register file.
- `WB_dest` out `REG_FILE_DEPTH`: registered destination.
- `WB_value` out `WORD_WIDTH`: registered write-back data.
- `mem_err` out 1: sticky error flag, cleared only by `rst`.

## Operation
- mem_op = `valid_in & (mem_R_en | mem_W_en)`; if both enables are high, the op is treated as a load.
- Word address = (`alu_result` − `BASE_ADDR`) >> 2, truncated to `ADDR_WIDTH`.
- Fault: `alu_result` < `BASE_ADDR`, or the shifted address ≥ 2^`ADDR_WIDTH`. On a fault there is no access and no freeze, the MEM/WB register takes a bubble, and `mem_err` is set.
- States:
  - `IDLE`:
    - Non-memory op: at the edge, load MEM/WB with `WB_en`=`WB_en_in & valid_in`, `WB_dest`=`dest_in`, `WB_value`=`alu_result`.
    - Valid mem_op without fault: assert `freeze`; at the edge, latch address, data and `we`, set `mem_req`=1, clear the counter, go to `WAIT`, and load a MEM/WB bubble (`WB_en`=0).
  - `WAIT`:
    - `mem_req` held, `freeze` = `!mem_ack`.
    - On `mem_ack`: at the edge, `mem_req`=0 and go to `IDLE`. MEM/WB loads `WB_en`=`WB_en_in` (load) or 0 (store), `WB_dest`=`dest_in`, `WB_value`=`mem_rdata`.
    - Without ack: the counter increments. When the counter = `TIMEOUT`−1 and there is no ack, abort: `mem_req`=0, `IDLE`, MEM/WB bubble, `mem_err`=1, `freeze` low in that cycle.
- `mem_ack` in `IDLE` is ignored.
- A store never writes a register.

## Timing
- Reset values: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `WB_en`, `WB_dest`, `WB_value`, `mem_err` all 0; state `IDLE`; counter 0. `freeze` = 0 while `rst` is high.
- Reset mid-access: `mem_req` drops asynchronously and any late `mem_ack` is ignored.
- Non-memory op: one-cycle latency to the MEM/WB outputs.
- Memory op presented in cycle 0:
  - `mem_req` high from cycle 1.
  - If ack arrives in cycle n≥1, the `WB_*` result appears after edge n+1.
  - `freeze` is high in cycles 0..n−1.
  - Minimum stall is one cycle.
- `mem_ack` and timeout in the same cycle: ack wins, no error.
- `mem_req` is never high in two consecutive accesses without an intervening `IDLE` cycle.

## Test plan
- Reset, then ALU op with `alu_result`=0x55, `dest_in`=3, `WB_en_in`=1 → next edge: `WB_en`=1, `WB_dest`=3, `WB_value`=0x55; `freeze` stays 0.
- Load at 0x408, `dest_in`=5, ack after 3 `WAIT` cycles with `mem_rdata`=0xDEADBEEF → `mem_addr`=2, `mem_we`=0; `freeze` high for 3 cycles; then `WB_en`=1, `WB_dest`=5, `WB_value`=0xDEADBEEF.
- Store at 0x400 with `val_Rm`=0x1234 and `WB_en_in`=1, ack in the first `WAIT` cycle → `mem_we`=1, `mem_addr`=0, `mem_wdata`=0x1234; `WB_en`=0; `freeze` high for 1 cycle.
- Load with no ack, `TIMEOUT`=16 → after 16 `WAIT` cycles: `mem_req`=0, `mem_err`=1, `WB_en`=0, `freeze` released. A later ALU op completes normally.
- Load at 0x3FC → no `mem_req`, `mem_err`=1, `WB_en`=0, no freeze.
- `rst` asserted in the 2nd `WAIT` cycle → `mem_req` and all outputs go to 0 immediately; a subsequent `mem_ack` produces no write-back.
